// File: rtl/if_fetch_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_fetch_buffer_pkg                                      |
// | Description : Shared types and constants for the instruction fetch     |
// |               stage: register/instruction bus types, reset PC and      |
// |               the 96-bit buffered fetch entry {pc, inst}.              |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package if_fetch_buffer_pkg;

  localparam int REG_W   = 64;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = REG_W + INST_W;

  typedef logic [REG_W-1:0]  reg_bus_t;
  typedef logic [INST_W-1:0] inst_bus_t;

  localparam reg_bus_t DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam reg_bus_t PC_STEP          = 64'd4;

  // One buffered fetch: pc in the upper 64 bits, instruction in the lower 32.
  typedef struct packed {
    reg_bus_t  pc;
    inst_bus_t inst;
  } fetch_entry_t;

  // Instructions are word aligned; the two low address bits are forced to zero.
  function automatic reg_bus_t align_pc(input reg_bus_t pc);
    return pc & ~reg_bus_t'(3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_fetch_buffer_if                                       |
// | Description : Bundles the fetch-stage handshakes: instruction memory   |
// |               request/response, execute redirect and decode output.    |
// | Modports    : master - fetch stage side (drives requests and decode)   |
// |               slave  - environment side (memory, execute, decode)      |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface if_fetch_buffer_if;
  import if_fetch_buffer_pkg::*;

  // Instruction memory request channel
  logic      imem_req_valid;
  logic      imem_req_ready;
  reg_bus_t  imem_req_addr;
  // Instruction memory response channel (in order, no backpressure)
  logic      imem_resp_valid;
  inst_bus_t imem_resp_data;
  // Control-flow redirect from execute
  logic      redirect_valid;
  reg_bus_t  redirect_pc;
  // Decode channel
  logic      inst_valid;
  logic      inst_ready;
  inst_bus_t inst;
  reg_bus_t  inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface

`default_nettype wire

// File: rtl/if_fetch_buffer_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_fetch_buffer_fetch_fifo                               |
// | Description : Synchronous DEPTH x 96 FIFO holding fetched {pc, inst}   |
// |               entries. Flush empties it and beats push/pop.            |
// | Ports       : clk, rst        - clock, synchronous active-high reset   |
// |               i_push/i_entry  - write an entry (caller guarantees room)|
// |               i_pop           - drop the head entry                    |
// |               i_flush         - discard all entries                    |
// |               o_full/o_empty  - occupancy flags                        |
// |               o_count         - number of stored entries               |
// |               o_head          - oldest entry                           |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module if_fetch_buffer_fetch_fifo
  import if_fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_push,
  input  wire fetch_entry_t  i_entry,
  input  wire logic          i_pop,
  input  wire logic          i_flush,
  output logic               o_full,
  output logic               o_empty,
  output logic [CW-1:0]      o_count,
  output fetch_entry_t       o_head
);

  localparam logic [PW-1:0] c_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop_ok;

  // Popping an empty FIFO is a no-op rather than an underflow.
  assign w_pop_ok = i_pop && (r_count != '0);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (i_push && !w_pop_ok) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!i_push && w_pop_ok) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Storage needs no reset: nothing is read while the count is zero.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/if_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_fetch_buffer                                          |
// | Description : Instruction fetch stage with prefetch buffer. Owns the   |
// |               PC, issues in-order fetches under a credit limit of      |
// |               DEPTH (buffered + in flight), buffers responses and      |
// |               presents {inst, pc} to decode. A redirect flushes the    |
// |               buffer and discards responses still owed to old fetches.|
// | Ports       : clk  - clock                                             |
// |               rst  - synchronous active-high reset                     |
// |               fb   - fetch bundle (memory, redirect, decode channels)  |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int       DEPTH    = 4,
  parameter reg_bus_t RESET_PC = DEFAULT_RESET_PC
) (
  input wire logic           clk,
  input wire logic           rst,
  if_fetch_buffer_if.master  fb
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0]   c_DEPTH  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] c_ONE    = CW'(1);

  reg_bus_t      r_fetch_pc;     // address of the next request
  reg_bus_t      r_resp_pc;      // pc belonging to the next kept response
  logic [CW-1:0] r_outstanding;  // accepted requests awaiting a response
  logic [CW-1:0] r_drop_cnt;     // responses still owed to pre-redirect fetches

  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] w_occ;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  reg_bus_t      w_redirect_pc;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_resp;
  logic          w_stale;
  logic          w_push;
  logic          w_inst_valid;
  logic          w_pop;

  // Credit: never let buffered + in-flight exceed what the buffer can hold,
  // so every kept response is guaranteed a slot.
  assign w_req_valid = !rst && (({1'b0, w_occ} + {1'b0, r_outstanding}) < c_DEPTH);
  assign w_fire      = w_req_valid && fb.imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp  = fb.imem_resp_valid && (r_outstanding != '0);
  assign w_stale = w_resp && (r_drop_cnt != '0);

  assign w_inst_valid = !rst && !w_empty;
  assign w_pop        = w_inst_valid && fb.inst_ready;

  // A redirect discards a same-cycle response even when it is not stale.
  // The full guard is belt and braces; credits already keep room available.
  assign w_push = w_resp && !w_stale && !fb.redirect_valid && (!w_full || w_pop);

  assign w_push_entry  = '{pc: r_resp_pc, inst: fb.imem_resp_data};
  assign w_redirect_pc = align_pc(fb.redirect_pc);

  always_comb begin
    w_outstanding_next = r_outstanding;
    unique case ({w_fire, w_resp})
      2'b10:   w_outstanding_next = r_outstanding + c_ONE;
      2'b01:   w_outstanding_next = r_outstanding - c_ONE;
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  // drop_cnt > 0 is the FLUSH condition; it returns to RUN once the last
  // stale response has been swallowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (fb.redirect_valid) begin
        // Everything still owed after this cycle belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_drop_cnt <= w_outstanding_next;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + PC_STEP;
        end
        if (w_stale) begin
          r_drop_cnt <= r_drop_cnt - c_ONE;
        end
      end
    end
  end

  if_fetch_buffer_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (fb.redirect_valid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ),
    .o_head  (w_head)
  );

  assign fb.imem_req_valid = w_req_valid;
  assign fb.imem_req_addr  = r_fetch_pc;
  assign fb.inst_valid     = w_inst_valid;
  assign fb.inst           = rst ? '0 : w_head.inst;
  assign fb.inst_pc        = rst ? '0 : w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_if_fetch_buffer                                       |
// | Description : Self-checking bench for if_fetch_buffer. A memory model  |
// |               returns a word derived from the address; a queue model   |
// |               of the buffer and of in-flight fetches (tagged with a    |
// |               redirect epoch) predicts every output each cycle.        |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_if_fetch_buffer;
  import if_fetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_buffer_if fb_if ();

  if_fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (DEFAULT_RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fb  (fb_if)
  );

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t         mem_q[$];     // accepted fetches not yet answered, in order
  logic [95:0]  exp_buf[$];   // entries decode should see, {pc, inst}
  logic [63:0]  m_fetch_pc = DEFAULT_RESET_PC;
  int           epoch = 0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  int           k_ready = 100;
  int           k_pop = 100;
  int           k_redir = 0;
  int           k_lat_max = 1;
  int           k_spur = 0;
  bit           f_redir = 0;
  logic [63:0]  f_pc = '0;
  int           fire_cnt = 0;
  int           pop_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the events of this cycle.
  task automatic step(input bit r);
    logic        exp_v;
    logic        fire;
    logic        resp_v;
    logic        redir;
    logic [63:0] tgt;
    req_t        e;
    int          due;

    @(negedge clk);
    rst = r;
    fb_if.imem_req_ready = ($urandom_range(99) < k_ready);
    resp_v = 1'b0;
    if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) resp_v = 1'b1;
    else if (!r && mem_q.size() == 0 && $urandom_range(99) < k_spur) resp_v = 1'b1;
    fb_if.imem_resp_valid = resp_v;
    fb_if.imem_resp_data  = (resp_v && mem_q.size() > 0) ? mem_word(mem_q[0].addr) : $urandom;
    fb_if.inst_ready      = ($urandom_range(99) < k_pop);
    redir = f_redir || ($urandom_range(99) < k_redir);
    tgt   = f_redir ? f_pc : {$urandom, $urandom};
    f_redir = 1'b0;
    fb_if.redirect_valid = redir;
    fb_if.redirect_pc    = tgt;
    #1;

    exp_v = !r && ((exp_buf.size() + mem_q.size()) < DEPTH);
    chk_eq("req_valid", fb_if.imem_req_valid, exp_v);
    if (exp_v) chk_eq("req_addr", fb_if.imem_req_addr, m_fetch_pc);
    chk_eq("inst_valid", fb_if.inst_valid, !r && exp_buf.size() != 0);
    if (r) begin
      chk_eq("rst_inst", fb_if.inst, 0);
      chk_eq("rst_inst_pc", fb_if.inst_pc, 0);
    end else if (exp_buf.size() != 0) begin
      chk_eq("head", {fb_if.inst_pc, fb_if.inst}, exp_buf[0]);
    end

    if (fb_if.imem_req_valid && fb_if.imem_req_ready) fire_cnt++;
    if (fb_if.inst_valid && fb_if.inst_ready) pop_cnt++;

    fire = exp_v && fb_if.imem_req_ready;
    if (r) begin
      mem_q.delete();
      exp_buf.delete();
      m_fetch_pc = DEFAULT_RESET_PC;
      epoch++;
    end else begin
      if (exp_buf.size() != 0 && fb_if.inst_ready) void'(exp_buf.pop_front());
      if (resp_v && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (e.epoch == epoch) exp_buf.push_back({e.addr, mem_word(e.addr)});
      end
      if (fire) begin
        due = cyc + $urandom_range(k_lat_max, 1);
        if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
        mem_q.push_back('{m_fetch_pc, epoch, due});
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
      if (redir) begin
        exp_buf.delete();
        epoch++;
        m_fetch_pc = tgt & ~64'h3;
      end
    end
    cyc++;
  endtask

  initial begin
    fb_if.imem_req_ready  = 1'b0;
    fb_if.imem_resp_valid = 1'b0;
    fb_if.imem_resp_data  = '0;
    fb_if.redirect_valid  = 1'b0;
    fb_if.redirect_pc     = '0;
    fb_if.inst_ready      = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1);

    // Decode stalled: credits must stop fetching after DEPTH requests.
    k_ready = 100; k_pop = 0; k_lat_max = 1; k_redir = 0;
    fire_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk_eq("stall_fires", fire_cnt, DEPTH);

    // Release decode: drain in order, then stream one per cycle.
    k_pop = 100;
    for (int i = 0; i < 20; i++) step(1'b0);
    pop_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk_eq("throughput", pop_cnt, 20);

    // Random traffic with redirects, variable latency and stalls.
    k_ready = 70; k_pop = 60; k_redir = 5; k_lat_max = 4;
    for (int i = 0; i < 500; i++) step(1'b0);
    k_ready = 100; k_pop = 100; k_redir = 15; k_lat_max = 3;
    for (int i = 0; i < 300; i++) step(1'b0);

    // Reset in the middle of traffic, then a stray response right after.
    k_redir = 0; k_pop = 0; k_lat_max = 3;
    for (int i = 0; i < 6; i++) step(1'b0);
    step(1'b1);
    k_spur = 100;
    step(1'b0);
    k_spur = 0; k_pop = 80; k_ready = 80;
    for (int i = 0; i < 40; i++) step(1'b0);

    // PC wrap-around near the top of the address space.
    k_ready = 100; k_pop = 100; k_lat_max = 2;
    f_redir = 1'b1; f_pc = 64'hFFFF_FFFF_FFFF_FFF6;
    for (int i = 0; i < 30; i++) step(1'b0);

    // Random again including occasional stray responses.
    k_ready = 60; k_pop = 70; k_redir = 4; k_lat_max = 5; k_spur = 10;
    for (int i = 0; i < 300; i++) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
Instruction fetch stage with a prefetch buffer. It sits upstream of the decode stage and between instruction memory and decode.
- Owns the PC and issues in-order fetch requests to instruction memory over a valid/ready handshake.
- Keeps up to DEPTH fetches in flight or buffered, and presents {inst, pc} to decode over a valid/ready handshake.
- A redirect from execute flushes the buffer and discards stale in-flight responses.

Parameters:
DEPTH, 4, buffer entries and maximum in-flight plus buffered fetches (power of 2, ≥2)
RESET_PC, 64'h0000_0000_8000_0000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address (REG_BUS), bits[1:0]=0
imem_resp_valid  in  1  instruction returned (in order, no backpressure)
imem_resp_data  in  32  returned instruction
redirect_valid  in  1  control-flow change from execute
redirect_pc  in  64  new PC; bits[1:0] ignored (treated as 0)
inst_valid  out  1  buffer head valid to decode
inst_ready  in  1  decode consumes head
inst  out  32  head instruction
inst_pc  out  64  PC of head instruction

Behaviour:
- Reset (rst high at a clk edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Buffer empty; outstanding=0, drop_cnt=0.
  - While rst is high: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- Reset mid-operation discards all buffered entries and in-flight state. Responses arriving after reset is released are counted against outstanding=0 and ignored.
- Credit rule: imem_req_valid = !rst && (occupancy + outstanding < DEPTH).
  - outstanding counts accepted requests not yet responded to, including ones pending drop.
- Request fire = imem_req_valid && imem_req_ready:
  - outstanding+1;
  - fetch_pc += 4, 64-bit wrap-around.
- imem_req_addr = fetch_pc. It is stable while valid && !ready, except in a redirect cycle, where it may change.
- Response (imem_resp_valid):
  - outstanding−1.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Else: push {imem_resp_data, resp_pc} and set resp_pc += 4.
  - A response with outstanding==0 is ignored (protocol error; no state change).
- Credits guarantee a push never overflows the buffer.
- Output: inst_valid = occupancy≠0; inst/inst_pc are the head entry. Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
- Latency: request accepted in cycle N, response in cycle M ⇒ inst_valid no earlier than M+1 (registered buffer, no bypass).
- Throughput: 1 inst/cycle sustained when memory latency ≤ DEPTH−1 and decode is always ready.
- Redirect (priority over every other event in the same cycle). Next edge:
  - fetch_pc = resp_pc = {redirect_pc[63:2],2'b00};
  - buffer cleared (a same-cycle pop is irrelevant);
  - drop_cnt = outstanding_next, i.e. outstanding after this cycle's request fire and response. A same-cycle response is discarded, and a same-cycle fired request counts toward drop_cnt.
- New requests may issue in the cycle after a redirect while drop_cnt>0. In-order responses guarantee the first drop_cnt responses are stale.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding; the last redirect wins.
- Counter widths: outstanding and drop_cnt are $clog2(DEPTH+1) bits; occupancy is $clog2(DEPTH+1) bits.
- Effective states:
  - RESET;
  - RUN (drop_cnt=0);
  - FLUSH (drop_cnt>0), which returns to RUN when the last stale response arrives.
  - Encode explicitly or derive from drop_cnt; observable behaviour must be identical.

Decomposition:
- Shared defines: REG_BUS (63:0), INST_BUS (31:0), RESET_PC constant, and fetch-entry width (96 bits: {pc, inst}).
- One natural sub-module: fetch_fifo.
  - Synchronous FIFO, DEPTH×96.
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush has priority over push/pop.

Test Plan:
1. Reset, memory ready=1, fixed 1-cycle latency, decode ready=1 → requests at 0x8000_0000, _0004, _0008…. inst_pc follows the same sequence one per cycle, first inst_valid 2 cycles after the first request fire.
2. Decode ready=0 for 20 cycles with an instant-response memory → exactly 4 requests issued, imem_req_valid=0 thereafter, occupancy=4. Release ready → 4 entries drain in order, then fetching resumes at 0x8000_0010.
3. Memory latency 3, 3 requests in flight, redirect_pc=0x8000_0102 → drop_cnt=3. The next 3 responses are discarded. The first inst_valid carries inst_pc=0x8000_0100 with the data of the first post-redirect request.
4. Redirect in the same cycle as a response, a request fire and a decode pop → response discarded, fired request counted in drop_cnt, buffer empty next cycle, fetch_pc=redirect target.
5. Assert rst for 1 cycle with 2 buffered entries and 2 in flight → inst_valid=0 and imem_req_valid=0 during reset. The following fetch starts at 0x8000_0000. Stale responses do not enter the buffer.
6. fetch_pc=0xFFFF_FFFF_FFFF_FFFC → next request address 0x0 (wrap-around), inst_pc sequence wraps identically.
